// File: rtl/orion_types.sv
`default_nettype none
// ============================================================================
//  Module      : orion_types (package)
//  Description : Shared types for the Orion core: M-extension operation
//                encoding (shared with decode and execute), muldiv FSM state
//                encoding, and the execute-stage M-extension enable.
//  Revision    : 1.0 - initial release
// ============================================================================
package orion_types;

   // M-extension operation, encoded as the RISC-V funct3 field
   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mul_op_t;

   // Iterative multiply/divide sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

   // Execute instantiates muldiv_iter when this is set
   localparam bit EN_RV32M_EXT = 1'b1;

   // Divide/remainder family (funct3[2] set)
   function automatic logic op_is_div(input mul_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   // Operations that interpret rs1 as two's complement
   function automatic logic op_signed_a(input mul_op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // Operations that interpret rs2 as two's complement
   function automatic logic op_signed_b(input mul_op_t op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_signfix
//  Description : Combinational sign handling for the iterative mul/div unit.
//                Entry side: operand magnitudes and negate flags.
//                Exit side : negate product/quotient/remainder and select the
//                            result half for the completed operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix
   import orion_types::*;
#(
   parameter int XLEN = 32
) (
   input  mul_op_t           in_op,
   input  logic [XLEN-1:0]   in_a,
   input  logic [XLEN-1:0]   in_b,
   output logic [XLEN-1:0]   abs_a,
   output logic [XLEN-1:0]   abs_b,
   output logic              in_neg_a,
   output logic              in_neg_b,
   input  mul_op_t           out_op,
   input  logic [2*XLEN-1:0] acc,
   input  logic              out_neg_a,
   input  logic              out_neg_b,
   output logic [XLEN-1:0]   result
);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   // Entry: magnitudes are unsigned; the most negative value maps onto itself
   always_comb begin
      in_neg_a = op_signed_a(in_op) && in_a[XLEN-1];
      in_neg_b = op_signed_b(in_op) && in_b[XLEN-1];
      abs_a    = in_neg_a ? -in_a : in_a;
      abs_b    = in_neg_b ? -in_b : in_b;
   end

   // Exit: quotient in acc low half, remainder in acc high half
   always_comb begin
      prod   = (out_neg_a ^ out_neg_b) ? -acc : acc;
      quo    = (out_neg_a ^ out_neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem    = out_neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      result = rem;
      case (out_op)
         OP_MUL:                        result = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               result = quo;
         default:                       result = rem;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Multi-cycle RV32M/RV64M multiply/divide unit. Shift-add
//                multiply retiring MUL_BPC multiplier bits per cycle and a
//                restoring divide producing one quotient bit per cycle.
//                Request and response use valid/ready handshakes.
//                Optional macro MULDIV_REUSE_EN: remember the last completed
//                divide and answer an identical divide/remainder in 1 cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
   import orion_types::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_BPC = 4,
   parameter int TAGW    = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  mul_op_t         req_op_i,
   input  logic [XLEN-1:0] req_a_i,
   input  logic [XLEN-1:0] req_b_i,
   input  logic [TAGW-1:0] req_tag_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] resp_result_o,
   output logic [TAGW-1:0] resp_tag_o,
   output logic            busy_o
);

   localparam int MUL_STEPS = XLEN / MUL_BPC;
   localparam int CNTW      = $clog2(XLEN + 1);

   muldiv_state_t     state;
   mul_op_t           op;
   logic [TAGW-1:0]   tag;
   logic [XLEN-1:0]   opa;        // multiplicand magnitude
   logic [XLEN-1:0]   opb;        // multiplier (shifting) or divisor magnitude
   logic [2*XLEN-1:0] acc;        // product, or {remainder, dividend/quotient}
   logic              neg_a;
   logic              neg_b;
   logic [CNTW-1:0]   cnt;

   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              in_neg_a;
   logic              in_neg_b;
   logic [XLEN-1:0]   fix_result;

   logic              div_zero;
   logic              div_ovf;
   logic [XLEN+MUL_BPC-1:0] mul_part;
   logic [XLEN+MUL_BPC-1:0] mul_top;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     rem_shift;
   logic [XLEN:0]     rem_trial;
   logic [2*XLEN-1:0] div_next;

`ifdef MULDIV_REUSE_EN
   logic [XLEN-1:0]   raw_a;
   logic [XLEN-1:0]   raw_b;
   logic              store_valid;
   logic [XLEN-1:0]   store_a;
   logic [XLEN-1:0]   store_b;
   logic              store_signed;
   logic [2*XLEN-1:0] store_acc;
   logic              store_neg_a;
   logic              store_neg_b;
   logic              reuse_hit;
`endif

   muldiv_signfix #(
      .XLEN (XLEN)
   ) u_signfix (
      .in_op     (req_op_i),
      .in_a      (req_a_i),
      .in_b      (req_b_i),
      .abs_a     (abs_a),
      .abs_b     (abs_b),
      .in_neg_a  (in_neg_a),
      .in_neg_b  (in_neg_b),
      .out_op    (op),
      .acc       (acc),
      .out_neg_a (neg_a),
      .out_neg_b (neg_b),
      .result    (fix_result)
   );

   // Special divides that bypass iteration, and one multiply/divide step
   always_comb begin
      div_zero  = (req_b_i == '0);
      div_ovf   = ((req_op_i == OP_DIV) || (req_op_i == OP_REM)) &&
                  (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (req_b_i == '1);
      // Add |a|*digit to the high half, then shift the whole accumulator right
      mul_part  = {{MUL_BPC{1'b0}}, opa} * {{XLEN{1'b0}}, opb[MUL_BPC-1:0]};
      mul_top   = {{MUL_BPC{1'b0}}, acc[2*XLEN-1:XLEN]} + mul_part;
      mul_next  = {mul_top, acc[XLEN-1:MUL_BPC]};
      // Restoring step: shift in next dividend bit, subtract divisor if it fits
      rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      rem_trial = rem_shift - {1'b0, opb};
      div_next  = rem_trial[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {rem_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   end

`ifdef MULDIV_REUSE_EN
   // Stored divide matches when operands and signedness are identical
   always_comb begin
      reuse_hit = store_valid && op_is_div(req_op_i) &&
                  (req_a_i == store_a) && (req_b_i == store_b) &&
                  (op_signed_a(req_op_i) == store_signed);
   end
`endif

   // Sequencer with registered handshake outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         req_ready_o   <= 1'b1;
         resp_valid_o  <= 1'b0;
         busy_o        <= 1'b0;
         resp_result_o <= '0;
         resp_tag_o    <= '0;
         op            <= OP_MUL;
         tag           <= '0;
         opa           <= '0;
         opb           <= '0;
         acc           <= '0;
         neg_a         <= 1'b0;
         neg_b         <= 1'b0;
         cnt           <= '0;
`ifdef MULDIV_REUSE_EN
         raw_a         <= '0;
         raw_b         <= '0;
         store_valid   <= 1'b0;
         store_a       <= '0;
         store_b       <= '0;
         store_signed  <= 1'b0;
         store_acc     <= '0;
         store_neg_a   <= 1'b0;
         store_neg_b   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i && !flush_i) begin
                  op          <= req_op_i;
                  tag         <= req_tag_i;
                  cnt         <= '0;
                  opa         <= abs_a;
                  opb         <= abs_b;
                  neg_a       <= in_neg_a;
                  neg_b       <= in_neg_b;
                  req_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
`ifdef MULDIV_REUSE_EN
                  raw_a       <= req_a_i;
                  raw_b       <= req_b_i;
`endif
                  if (!op_is_div(req_op_i)) begin
                     acc   <= '0;
                     state <= MUL;
`ifdef MULDIV_REUSE_EN
                  end else if (reuse_hit) begin
                     acc   <= store_acc;
                     neg_a <= store_neg_a;
                     neg_b <= store_neg_b;
                     state <= DONE;
`endif
                  end else if (div_zero) begin
                     // quotient all-ones, remainder is the dividend
                     acc   <= {req_a_i, {XLEN{1'b1}}};
                     neg_a <= 1'b0;
                     neg_b <= 1'b0;
                     state <= DONE;
                  end else if (div_ovf) begin
                     // quotient is the dividend, remainder zero
                     acc   <= {{XLEN{1'b0}}, req_a_i};
                     neg_a <= 1'b0;
                     neg_b <= 1'b0;
                     state <= DONE;
                  end else begin
                     acc   <= {{XLEN{1'b0}}, abs_a};
                     state <= DIV;
                  end
               end
            end
            MUL: begin
               if (flush_i) begin
                  state       <= IDLE;
                  req_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
               end else begin
                  acc <= mul_next;
                  opb <= opb >> MUL_BPC;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNTW'(MUL_STEPS - 1)) begin
                     state <= DONE;
                  end
               end
            end
            DIV: begin
               if (flush_i) begin
                  state       <= IDLE;
                  req_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
               end else begin
                  acc <= div_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNTW'(XLEN - 1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (flush_i) begin
                  state        <= IDLE;
                  resp_valid_o <= 1'b0;
                  req_ready_o  <= 1'b1;
                  busy_o       <= 1'b0;
               end else if (!resp_valid_o) begin
                  // first DONE cycle: sign-fix and present the result
                  resp_valid_o  <= 1'b1;
                  resp_result_o <= fix_result;
                  resp_tag_o    <= tag;
               end else if (resp_ready_i) begin
                  state        <= IDLE;
                  resp_valid_o <= 1'b0;
                  req_ready_o  <= 1'b1;
                  busy_o       <= 1'b0;
`ifdef MULDIV_REUSE_EN
                  if (op_is_div(op)) begin
                     store_valid  <= 1'b1;
                     store_a      <= raw_a;
                     store_b      <= raw_b;
                     store_signed <= op_signed_a(op);
                     store_acc    <= acc;
                     store_neg_a  <= neg_a;
                     store_neg_b  <= neg_b;
                  end
`endif
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
`ifdef MULDIV_REUSE_EN
         if (flush_i) begin
            store_valid <= 1'b0;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_iter
//  Description : Directed self-checking bench for muldiv_iter (XLEN=32,
//                MUL_BPC=4). Honours MULDIV_REUSE_EN for the reuse latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;
   import orion_types::*;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   mul_op_t     req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_tag;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic [4:0]  resp_tag;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_iter #(
      .XLEN    (32),
      .MUL_BPC (4),
      .TAGW    (5)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_op_i      (req_op),
      .req_a_i       (req_a),
      .req_b_i       (req_b),
      .req_tag_i     (req_tag),
      .flush_i       (flush),
      .resp_valid_o  (resp_valid),
      .resp_ready_i  (resp_ready),
      .resp_result_o (resp_result),
      .resp_tag_o    (resp_tag),
      .busy_o        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one request for a single edge; unit is expected idle
   task automatic issue(input mul_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
      check_eq("ready_before_issue", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_op    = o;
      req_a     = a;
      req_b     = b;
      req_tag   = t;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Count cycles from accept until resp_valid, bounded
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input mul_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      issue(o, a, b, t);
      wait_resp(lat);
      check_eq({name, "_valid"}, {63'd0, resp_valid}, 64'd1);
      if (resp_valid) begin
         check_eq({name, "_result"}, {32'd0, resp_result}, {32'd0, exp});
         check_eq({name, "_tag"}, {59'd0, resp_tag}, {59'd0, t});
         check_eq({name, "_latency"}, 64'(lat), 64'(exp_lat));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      int seen;
      int reuse_lat;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = OP_MUL;
      req_a      = '0;
      req_b      = '0;
      req_tag    = '0;
      flush      = 1'b0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check_eq("rst_req_ready",  {63'd0, req_ready},  64'd1);
      check_eq("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check_eq("rst_busy",       {63'd0, busy},       64'd0);
      check_eq("rst_result",     {32'd0, resp_result}, 64'd0);
      check_eq("rst_tag",        {59'd0, resp_tag},   64'd0);

      // Multiply family
      run_op("mul_7_m3",     OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 9);
      run_op("mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 9);
      run_op("mulh_m2_3",    OP_MULH,   32'hFFFFFFFE, 32'd3,        5'd3, 32'hFFFFFFFF, 9);
      run_op("mulh_min_min", OP_MULH,   32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 9);
      run_op("mulhsu_m1",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF, 9);

      // Divide family
      run_op("div_m20_3",   OP_DIV,  32'hFFFFFFEC, 32'd3, 5'd6, 32'hFFFFFFFA, 33);
      run_op("rem_m20_3",   OP_REM,  32'hFFFFFFEC, 32'd3, 5'd7, 32'hFFFFFFFE, 33);
      run_op("divu_100_7",  OP_DIVU, 32'd100,      32'd7, 5'd8, 32'd14,       33);
      run_op("remu_100_7",  OP_REMU, 32'd100,      32'd7, 5'd9, 32'd2,        33);

      // Special divides
      run_op("divu_by_zero", OP_DIVU, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1);
      run_op("remu_by_zero", OP_REMU, 32'd5,        32'd0,        5'd11, 32'd5,        1);
      run_op("rem_ovf",      OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1);
      run_op("div_ovf",      OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1);

      // Back-pressure: result held with resp_ready low for 10 cycles
      resp_ready = 1'b0;
      issue(OP_MUL, 32'd6, 32'd7, 5'd21);
      wait_resp(lat);
      check_eq("bp_latency", 64'(lat), 64'd9);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_eq("bp_result",    {32'd0, resp_result}, 64'd42);
         check_eq("bp_tag",       {59'd0, resp_tag},    64'd21);
         check_eq("bp_valid",     {63'd0, resp_valid},  64'd1);
         check_eq("bp_req_ready", {63'd0, req_ready},   64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_release_ready", {63'd0, req_ready},  64'd1);
      check_eq("bp_release_valid", {63'd0, resp_valid}, 64'd0);
      run_op("after_bp", OP_MUL, 32'd11, 32'd13, 5'd22, 32'd143, 9);

      // Flush in IDLE blocks acceptance
      req_valid = 1'b1;
      req_op    = OP_MUL;
      req_a     = 32'd3;
      req_b     = 32'd3;
      flush     = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      check_eq("idle_flush_busy",  {63'd0, busy},      64'd0);
      check_eq("idle_flush_ready", {63'd0, req_ready}, 64'd1);

      // Flush on cycle 12 of a divide
      issue(OP_DIVU, 32'd1000, 32'd3, 5'd23);
      repeat (11) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_eq("flush_valid", {63'd0, resp_valid}, 64'd0);
      check_eq("flush_ready", {63'd0, req_ready},  64'd1);
      check_eq("flush_busy",  {63'd0, busy},       64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      check_eq("flush_no_resp", 64'(seen), 64'd0);

      // Reset mid-multiply
      issue(OP_MUL, 32'd9, 32'd9, 5'd24);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("midrst_ready",  {63'd0, req_ready},   64'd1);
      check_eq("midrst_valid",  {63'd0, resp_valid},  64'd0);
      check_eq("midrst_busy",   {63'd0, busy},        64'd0);
      check_eq("midrst_result", {32'd0, resp_result}, 64'd0);
      check_eq("midrst_tag",    {59'd0, resp_tag},    64'd0);

      // Divide result reuse across an intervening multiply
`ifdef MULDIV_REUSE_EN
      reuse_lat = 1;
`else
      reuse_lat = 33;
`endif
      run_op("reuse_div", OP_DIV,  32'd100, 32'd7, 5'd25, 32'd14, 33);
      run_op("reuse_mul", OP_MUL,  32'd3,   32'd4, 5'd26, 32'd12, 9);
      run_op("reuse_rem", OP_REM,  32'd100, 32'd7, 5'd27, 32'd2,  reuse_lat);
      run_op("reuse_divu_diff_sign", OP_DIVU, 32'd100, 32'd7, 5'd28, 32'd14, 33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
